// File: rtl/lc3_mem_arb.sv
// lc3_mem_arb
// Shares the LC3's single-port RAM between the core (requester 0) and the
// debug/program loader (requester 1). One access is accepted per cycle. The
// accepted access is presented to the RAM from registers on the following
// cycle. Read data is routed back to whichever requester issued the read.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata    access request from requester N
//   reqN_gnt                    request accepted this cycle (combinational)
//   reqN_rvalid/rdata           read data return to requester N
//   req1_lock                   loader asks for back-to-back grants
//   mem_en/we/mem_addr/ram_data registered RAM command
//   mem_data                    RAM read data, RD_LAT cycles after mem_en
module lc3_mem_arb #(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_gnt,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_wdata,
    input  logic        req1_lock,
    output logic        req1_gnt,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    output logic        mem_en,
    output logic        we,
    output logic [15:0] mem_addr,
    output logic [15:0] ram_data,
    input  logic [15:0] mem_data
);

    // last = 1 means requester 1 was granted most recently
    logic              last;
    logic [7:0]        lock_cnt;
    logic              lock_won;
    logic              limit_hit;
    logic              issue_own;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;

    assign lock_won  = req1_lock && req1_valid;
    assign limit_hit = lock_won && req0_valid && (lock_cnt == 8'(MAX_LOCK));

    // Grant selection: lock beats round-robin until the core has waited
    // through MAX_LOCK lock-won grants, then the core gets one slot.
    always_comb begin
        req0_gnt = 1'b0;
        req1_gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            if (lock_won) begin
                req0_gnt = limit_hit;
                req1_gnt = !limit_hit;
            end else begin
                req0_gnt = last;
                req1_gnt = !last;
            end
        end else begin
            req0_gnt = req0_valid;
            req1_gnt = req1_valid;
        end
    end

    // Round-robin pointer and lock counter. Only grants to 1 that actually
    // made the core wait are counted, so an uncontended burst never expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b1;
            lock_cnt <= 8'd0;
        end else begin
            if (req0_gnt) begin
                last <= 1'b0;
            end else if (req1_gnt) begin
                last <= 1'b1;
            end
            if (req0_gnt || !req1_lock) begin
                lock_cnt <= 8'd0;
            end else if (req1_gnt && lock_won && req0_valid) begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end
    end

    // RAM command register; address and data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            we        <= 1'b0;
            mem_addr  <= 16'h0000;
            ram_data  <= 16'h0000;
            issue_own <= 1'b0;
        end else if (req0_gnt || req1_gnt) begin
            mem_en    <= 1'b1;
            we        <= req1_gnt ? req1_we    : req0_we;
            mem_addr  <= req1_gnt ? req1_addr  : req0_addr;
            ram_data  <= req1_gnt ? req1_wdata : req0_wdata;
            issue_own <= req1_gnt;
        end else begin
            mem_en <= 1'b0;
            we     <= 1'b0;
        end
    end

    // Read tracking pipe: entry 0 is loaded from the read currently on the
    // RAM bus, so the last entry lines up with mem_data RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= mem_en && !we;
            pipe_own[0] <= issue_own;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign req0_rvalid = pipe_vld[RD_LAT-1] && !pipe_own[RD_LAT-1];
    assign req1_rvalid = pipe_vld[RD_LAT-1] &&  pipe_own[RD_LAT-1];
    assign req0_rdata  = mem_data;
    assign req1_rdata  = mem_data;

endmodule
